// File: rtl/clock_set_controller_pkg.sv
// Shared types for the clock-set controller: FSM state encoding and button-code helpers.
package clock_set_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_REPEAT  = 3'd2,
    ST_BOTH    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_BOTH = 2'b11;

  function automatic logic is_single(input logic [1:0] btn);
    return btn[1] ^ btn[0];
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_set_controller_debounce.sv
// One push-button: 2-FF synchroniser followed by a tick-paced debouncer.
module button_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick_stb,
  input  logic i_btn,
  output logic o_level,
  output logic o_flip
);

  localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_flip;

  assign w_mismatch = (r_sync2 != r_level);
  // High in the cycle whose tick completes the count, i.e. the level flips at this edge.
  assign w_flip     = i_tick_stb && w_mismatch && (r_cnt == CW'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (i_tick_stb) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_flip  = w_flip;

endmodule

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: debounced hours/minutes levels plus a set strobe with hold/auto-repeat.
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned HOLD_TICKS     = 50,
  parameter int unsigned REPEAT_TICKS   = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick_stb,
  input  logic i_btn_hours,
  input  logic i_btn_minutes,
  output logic o_set_hours,
  output logic o_set_minutes,
  output logic o_set_stb,
  output logic o_busy
);

  localparam int unsigned MAX_T = max_u(HOLD_TICKS, REPEAT_TICKS);
  localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_TICKS - 1);

  logic             w_deb_h, w_deb_m, w_flip_h, w_flip_m;
  logic [1:0]       w_btn;
  logic             w_changed, w_tick;
  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic             w_pulse;
  logic [1:0]       r_btn_last;
  logic             r_set_hours, r_set_minutes, r_set_stb, r_busy;

  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_hours (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick_stb(i_tick_stb),
    .i_btn(i_btn_hours), .o_level(w_deb_h), .o_flip(w_flip_h)
  );

  button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_minutes (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick_stb(i_tick_stb),
    .i_btn(i_btn_minutes), .o_level(w_deb_m), .o_flip(w_flip_m)
  );

  assign w_btn     = {w_deb_h, w_deb_m};
  assign w_changed = (w_btn != r_btn_last);
  // A tick that flips a debounced level belongs to the button change seen next cycle;
  // dropping it keeps a repeat strobe from abutting the new-press strobe.
  assign w_tick    = i_tick_stb && !(w_flip_h || w_flip_m);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pulse      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (is_single(w_btn)) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = HOLD_LOAD;
          w_pulse      = 1'b1;
        end else if (w_btn == BTN_BOTH) begin
          w_next_state = ST_BOTH;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (w_changed) begin
          if (w_btn == BTN_NONE) begin
            w_next_state = ST_IDLE;
          end else if (w_btn == BTN_BOTH) begin
            w_next_state = ST_BOTH;
          end else begin
            w_next_state = ST_HOLD;
            w_next_cnt   = HOLD_LOAD;
            w_pulse      = 1'b1;
          end
        end else if (w_tick) begin
          if (r_cnt == '0) begin
            w_next_state = ST_REPEAT;
            w_next_cnt   = REP_LOAD;
            w_pulse      = 1'b1;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_BOTH: begin
        if (w_btn == BTN_NONE)      w_next_state = ST_IDLE;
        else if (is_single(w_btn))  w_next_state = ST_LOCKOUT;
      end
      ST_LOCKOUT: begin
        if (w_btn == BTN_NONE)      w_next_state = ST_IDLE;
        else if (w_btn == BTN_BOTH) w_next_state = ST_BOTH;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_btn_last    <= '0;
      r_set_hours   <= 1'b0;
      r_set_minutes <= 1'b0;
      r_set_stb     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_btn_last    <= w_btn;
      r_set_hours   <= w_btn[1];
      r_set_minutes <= w_btn[0];
      r_set_stb     <= w_pulse;
      r_busy        <= (w_next_state != ST_IDLE);
    end
  end

  assign o_set_hours   = r_set_hours;
  assign o_set_minutes = r_set_minutes;
  assign o_set_stb     = r_set_stb;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench: tick every 4 clks, DEBOUNCE=4, HOLD=5, REPEAT=2; vectors are tick-aligned segments.
module tb_clock_set_controller;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_tick_stb = 1'b0;
  logic i_btn_hours = 1'b0;
  logic i_btn_minutes = 1'b0;
  logic o_set_hours, o_set_minutes, o_set_stb, o_busy;

  clock_set_controller #(
    .DEBOUNCE_TICKS(4),
    .HOLD_TICKS(5),
    .REPEAT_TICKS(2)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_tick_stb(i_tick_stb),
    .i_btn_hours(i_btn_hours),
    .i_btn_minutes(i_btn_minutes),
    .o_set_hours(o_set_hours),
    .o_set_minutes(o_set_minutes),
    .o_set_stb(o_set_stb),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // One segment: raw buttons held for a whole number of ticks; strobe cycles counted,
  // levels and busy checked at the end.
  typedef struct {
    logic h;
    logic m;
    int   ticks;
    int   stb;
    logic eh;
    logic em;
    logic ebusy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   ph = 0;
  int   stb_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    i_tick_stb = (ph == 0);
    @(posedge i_clk);
    #1;
    ph = (ph + 1) % 4;
    if (o_set_stb) stb_seen++;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    i_btn_hours   = v.h;
    i_btn_minutes = v.m;
    stb_seen      = 0;
    repeat (v.ticks * 4) cyc();
    chk({tag, ".stb"},  stb_seen,      v.stb);
    chk({tag, ".hrs"},  o_set_hours,   v.eh);
    chk({tag, ".min"},  o_set_minutes, v.em);
    chk({tag, ".busy"}, o_busy,        v.ebusy);
  endtask

  initial begin
    // Test 2: hours bounces every 2 ticks for 20 ticks, then stays low
    for (int i = 0; i < 10; i++) vecs.push_back('{(i % 2 == 0), 1'b0, 2, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0});
    // Test 3: minutes held; first strobe, 8 repeats, release (2 repeats during release latency)
    vecs.push_back('{1'b0, 1'b1, 5,  1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 19, 8, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 6,  2, 1'b0, 1'b0, 1'b0});
    // Test 4: hours, then both -> BOTH, drop minutes -> LOCKOUT, drop all -> IDLE
    vecs.push_back('{1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 6, 1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 5, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 6, 0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 6, 0, 1'b0, 1'b0, 1'b0});
    // Test 5: hours, switch straight to minutes -> one new strobe, repeat 5 ticks later
    vecs.push_back('{1'b1, 1'b0, 5, 1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 5, 1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 4, 0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1, 1, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 6, 2, 1'b0, 1'b0, 1'b0});

    // Test 1: reset with hours held, then debounce and a single strobe
    i_reset = 1'b1;
    i_btn_hours = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rst%0d", i), {o_set_hours, o_set_minutes, o_set_stb, o_busy}, 0);
    end
    i_reset = 1'b0;
    cyc();
    chk("rst_rel", {o_set_hours, o_set_minutes, o_set_stb, o_busy}, 0);
    apply_vec('{1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0}, "t1a");
    apply_vec('{1'b1, 1'b0, 2, 1, 1'b1, 1'b0, 1'b1}, "t1b");
    apply_vec('{1'b0, 1'b0, 6, 0, 1'b0, 1'b0, 1'b0}, "t1c");

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Test 6: reset while in REPEAT, then re-debounce and a fresh first strobe
    apply_vec('{1'b0, 1'b1, 5, 1, 1'b0, 1'b1, 1'b1}, "t6a");
    apply_vec('{1'b0, 1'b1, 6, 1, 1'b0, 1'b1, 1'b1}, "t6b");
    i_reset = 1'b1;
    stb_seen = 0;
    cyc();
    chk("t6_rst", {o_set_hours, o_set_minutes, o_set_stb, o_busy}, 0);
    i_reset = 1'b0;
    repeat (3) cyc();
    chk("t6_idle", {o_set_hours, o_set_minutes, o_set_stb, o_busy}, 0);
    chk("t6_nostb", stb_seen, 0);
    apply_vec('{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b0}, "t6c");
    apply_vec('{1'b0, 1'b1, 2, 1, 1'b0, 1'b1, 1'b1}, "t6d");
    apply_vec('{1'b0, 1'b0, 6, 1, 1'b0, 1'b0, 1'b0}, "t6e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
